// File: rtl/rr_cfg_axil_regfile.sv
// AXI-Lite slave holding the record/replay configuration registers and
// exposing read-only status words sampled from the RR core.
module rr_cfg_axil_regfile #(
    parameter int                       NUM_CFG       = 8,
    parameter int                       NUM_STAT      = 4,
    parameter logic [NUM_CFG*32-1:0]    CFG_RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [31:0]                 s_awaddr,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [31:0]                 s_wdata,
    input  logic [3:0]                  s_wstrb,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    input  logic [31:0]                 s_araddr,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [31:0]                 s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic [NUM_CFG*32-1:0]       cfg_regs,
    output logic [NUM_CFG-1:0]          cfg_wr_pulse,
    input  logic [NUM_STAT*32-1:0]      stat_in
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [8:0] CFG_LIM     = 9'(NUM_CFG);

    logic                   aw_held_q, aw_held_d;
    logic [7:0]             aw_idx_q, aw_idx_d;
    logic                   w_held_q, w_held_d;
    logic [31:0]            w_data_q, w_data_d;
    logic [3:0]             w_strb_q, w_strb_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [NUM_CFG*32-1:0]  cfg_q, cfg_d;
    logic [NUM_CFG-1:0]     pulse_q, pulse_d;

    logic                   aw_hs, w_hs, ar_hs, commit;
    logic [7:0]             wr_idx, rd_idx;
    logic [31:0]            wr_data;
    logic [3:0]             wr_strb;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[31:10], s_awaddr[1:0],
                                s_araddr[31:10], s_araddr[1:0]};

    assign s_awready    = !aw_held_q && !bvalid_q;
    assign s_wready     = !w_held_q && !bvalid_q;
    assign s_arready    = !rvalid_q;
    assign s_bvalid     = bvalid_q;
    assign s_bresp      = bresp_q;
    assign s_rvalid     = rvalid_q;
    assign s_rdata      = rdata_q;
    assign s_rresp      = rresp_q;
    assign cfg_regs     = cfg_q;
    assign cfg_wr_pulse = pulse_q;

    // Write path: either channel may be parked; commit uses whichever copy is live.
    always_comb begin
        aw_hs   = s_awvalid && s_awready;
        w_hs    = s_wvalid && s_wready;
        commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wr_idx  = aw_held_q ? aw_idx_q : s_awaddr[9:2];
        wr_data = w_held_q ? w_data_q : s_wdata;
        wr_strb = w_held_q ? w_strb_q : s_wstrb;

        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        cfg_d     = cfg_q;
        pulse_d   = '0;

        if (bvalid_q && s_bready) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if ({1'b0, wr_idx} < CFG_LIM) begin
                bresp_d = RESP_OKAY;
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (wr_idx == 8'(i)) begin
                        pulse_d[i] = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (wr_strb[b]) begin
                                cfg_d[32*i+8*b +: 8] = wr_data[8*b +: 8];
                            end
                        end
                    end
                end
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = s_awaddr[9:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = s_wdata;
                w_strb_d = s_wstrb;
            end
        end
    end

    // Read path: cfg_q is the pre-commit value, so a colliding read sees old data.
    always_comb begin
        ar_hs    = s_arvalid && s_arready;
        rd_idx   = s_araddr[9:2];
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            for (int i = 0; i < NUM_CFG; i++) begin
                if (rd_idx == 8'(i)) begin
                    rdata_d = cfg_q[32*i +: 32];
                    rresp_d = RESP_OKAY;
                end
            end
            for (int j = 0; j < NUM_STAT; j++) begin
                if (rd_idx == 8'(NUM_CFG + j)) begin
                    rdata_d = stat_in[32*j +: 32];
                    rresp_d = RESP_OKAY;
                end
            end
        end else if (rvalid_q && s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            cfg_q     <= CFG_RESET_VAL;
            pulse_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            cfg_q     <= cfg_d;
            pulse_q   <= pulse_d;
        end
    end

endmodule

// File: tb/tb_rr_cfg_axil_regfile.sv
// Randomised, self-checking bench for rr_cfg_axil_regfile against a
// word-array model of the register map.
module tb_rr_cfg_axil_regfile;

    localparam int NUM_CFG  = 8;
    localparam int NUM_STAT = 4;

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic [31:0]                s_awaddr = '0;
    logic                       s_awvalid = 1'b0;
    logic                       s_awready;
    logic [31:0]                s_wdata = '0;
    logic [3:0]                 s_wstrb = '0;
    logic                       s_wvalid = 1'b0;
    logic                       s_wready;
    logic [1:0]                 s_bresp;
    logic                       s_bvalid;
    logic                       s_bready = 1'b0;
    logic [31:0]                s_araddr = '0;
    logic                       s_arvalid = 1'b0;
    logic                       s_arready;
    logic [31:0]                s_rdata;
    logic [1:0]                 s_rresp;
    logic                       s_rvalid;
    logic                       s_rready = 1'b0;
    logic [NUM_CFG*32-1:0]      cfg_regs;
    logic [NUM_CFG-1:0]         cfg_wr_pulse;
    logic [NUM_STAT*32-1:0]     stat_in = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_cfg  [NUM_CFG];
    logic [31:0] model_stat [NUM_STAT];

    rr_cfg_axil_regfile #(.NUM_CFG(NUM_CFG), .NUM_STAT(NUM_STAT)) dut (
        .clk(clk), .rstn(rstn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse), .stat_in(stat_in)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NUM_CFG*32-1:0] model_flat();
        logic [NUM_CFG*32-1:0] r;
        for (int i = 0; i < NUM_CFG; i++) r[32*i +: 32] = model_cfg[i];
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CFG; i++) model_cfg[i] = '0;
    endtask

    task automatic set_stat(input int j, input logic [31:0] v);
        stat_in[32*j +: 32] = v;
        model_stat[j] = v;
    endtask

    // Bus driver: issues AW and W after independent delays, returns the B response.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output logic [NUM_CFG-1:0] pulse, output bit ok);
        bit aw_done, w_done, fire_aw, fire_w;
        aw_done = 0; w_done = 0; ok = 0; resp = 2'bxx; pulse = 'x;
        s_bready = 1'b1;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            s_awaddr  = addr; s_wdata = data; s_wstrb = strb;
            s_awvalid = !aw_done && (c >= aw_dly);
            s_wvalid  = !w_done && (c >= w_dly);
            fire_aw   = s_awvalid && s_awready;
            fire_w    = s_wvalid && s_wready;
            @(negedge clk);
            if (fire_aw) aw_done = 1;
            if (fire_w)  w_done  = 1;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int c = 0; c < 20 && aw_done && w_done; c++) begin
            if (s_bvalid) begin
                resp = s_bresp; pulse = cfg_wr_pulse; ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
        bit fired;
        fired = 0; ok = 0; data = 'x; resp = 2'bxx;
        s_rready = 1'b1;
        for (int c = 0; c < 20 && !fired; c++) begin
            s_araddr  = addr;
            s_arvalid = 1'b1;
            fired     = s_arready;
            @(negedge clk);
        end
        s_arvalid = 1'b0;
        for (int c = 0; c < 20 && fired; c++) begin
            if (s_rvalid) begin
                data = s_rdata; resp = s_rresp; ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_rready = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %b want 0", s_bvalid); end
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", s_rvalid); end
        checks++; if ({s_bresp, s_rresp} !== 4'b0) begin errors++; $display("FAIL reset_resp: got %b want 0000", {s_bresp, s_rresp}); end
        checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", s_rdata); end
        checks++; if (cfg_regs !== model_flat()) begin errors++; $display("FAIL reset_cfg: got %h want %h", cfg_regs, model_flat()); end
        checks++; if (cfg_wr_pulse !== '0) begin errors++; $display("FAIL reset_pulse: got %b want 0", cfg_wr_pulse); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", {s_awready, s_wready, s_arready}); end
    endtask

    task automatic test_basic_write();
        s_awaddr = 32'h8; s_wdata = 32'hA5A5_1234; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        model_cfg[2] = merge(model_cfg[2], 32'hA5A5_1234, 4'hF);
        checks++; if (cfg_regs[95:64] !== 32'hA5A5_1234) begin errors++; $display("FAIL basic_reg2: got %h want a5a51234", cfg_regs[95:64]); end
        checks++; if (cfg_regs !== model_flat()) begin errors++; $display("FAIL basic_cfg: got %h want %h", cfg_regs, model_flat()); end
        checks++; if (cfg_wr_pulse !== 8'b0000_0100) begin errors++; $display("FAIL basic_pulse: got %b want 00000100", cfg_wr_pulse); end
        checks++; if ({s_bvalid, s_bresp} !== 3'b100) begin errors++; $display("FAIL basic_b: got %b want 100", {s_bvalid, s_bresp}); end
        checks++; if ({s_awready, s_wready} !== 2'b00) begin errors++; $display("FAIL basic_ready_busy: got %b want 00", {s_awready, s_wready}); end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        checks++; if (cfg_wr_pulse !== '0) begin errors++; $display("FAIL basic_pulse_once: got %b want 0", cfg_wr_pulse); end
        checks++; if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin errors++; $display("FAIL basic_after_b: got %b want 011", {s_bvalid, s_awready, s_wready}); end
    endtask

    task automatic test_w_first();
        s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'b0101; s_wvalid = 1'b1; s_bready = 1'b0;
        @(negedge clk);
        s_wvalid = 1'b0;
        checks++; if ({s_wready, s_awready, s_bvalid} !== 3'b010) begin errors++; $display("FAIL wfirst_held: got %b want 010", {s_wready, s_awready, s_bvalid}); end
        repeat (2) @(negedge clk);
        s_awaddr = 32'h0; s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        model_cfg[0] = merge(model_cfg[0], 32'hFFFF_FFFF, 4'b0101);
        checks++; if (cfg_regs[31:0] !== 32'h00FF_00FF) begin errors++; $display("FAIL wfirst_reg0: got %h want 00ff00ff", cfg_regs[31:0]); end
        checks++; if (cfg_regs !== model_flat()) begin errors++; $display("FAIL wfirst_cfg: got %h want %h", cfg_regs, model_flat()); end
        checks++; if (cfg_wr_pulse !== 8'b0000_0001) begin errors++; $display("FAIL wfirst_pulse: got %b want 00000001", cfg_wr_pulse); end
        for (int k = 0; k < 2; k++) begin
            checks++; if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000) begin errors++; $display("FAIL wfirst_bhold%0d: got %b want 10000", k, {s_bvalid, s_bresp, s_awready, s_wready}); end
            @(negedge clk);
        end
        checks++; if (cfg_wr_pulse !== '0) begin errors++; $display("FAIL wfirst_pulse_once: got %b want 0", cfg_wr_pulse); end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        checks++; if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin errors++; $display("FAIL wfirst_release: got %b want 011", {s_bvalid, s_awready, s_wready}); end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [NUM_CFG-1:0] pulse; logic [31:0] rd; bit ok;
        axi_write(32'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, pulse, ok);
        checks++; if ({ok, resp, pulse} !== {1'b1, 2'b10, 8'h00}) begin errors++; $display("FAIL err_stat_wr: got ok=%b resp=%b pulse=%b want ok=1 resp=10 pulse=0", ok, resp, pulse); end
        axi_write(32'h3FC, 32'hCAFE_F00D, 4'hF, 1, 0, resp, pulse, ok);
        checks++; if ({ok, resp, pulse} !== {1'b1, 2'b10, 8'h00}) begin errors++; $display("FAIL err_unmap_wr: got ok=%b resp=%b pulse=%b want ok=1 resp=10 pulse=0", ok, resp, pulse); end
        checks++; if (cfg_regs !== model_flat()) begin errors++; $display("FAIL err_cfg: got %h want %h", cfg_regs, model_flat()); end
        axi_read(32'h3FC, rd, resp, ok);
        checks++; if ({ok, rd, resp} !== {1'b1, 32'h0, 2'b10}) begin errors++; $display("FAIL err_unmap_rd: got ok=%b data=%h resp=%b want ok=1 data=0 resp=10", ok, rd, resp); end
    endtask

    task automatic test_stat_read();
        set_stat(0, 32'h1111);
        s_araddr = 32'h20; s_arvalid = 1'b1; s_rready = 1'b0;
        checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL stat_arready: got %b want 1", s_arready); end
        @(negedge clk);
        s_arvalid = 1'b0;
        set_stat(0, 32'h2222);
        for (int k = 0; k < 3; k++) begin
            checks++; if ({s_rvalid, s_rdata, s_rresp, s_arready} !== {1'b1, 32'h1111, 2'b00, 1'b0}) begin errors++; $display("FAIL stat_hold%0d: got v=%b d=%h r=%b ar=%b want v=1 d=1111 r=00 ar=0", k, s_rvalid, s_rdata, s_rresp, s_arready); end
            @(negedge clk);
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        checks++; if ({s_rvalid, s_arready} !== 2'b01) begin errors++; $display("FAIL stat_release: got %b want 01", {s_rvalid, s_arready}); end
    endtask

    task automatic test_collide();
        logic [31:0] old_v, rd; logic [1:0] resp; bit ok;
        old_v = model_cfg[1];
        s_awaddr = 32'h4; s_wdata = 32'h7; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = 32'h4; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b0;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        model_cfg[1] = merge(model_cfg[1], 32'h7, 4'hF);
        checks++; if ({s_rvalid, s_rdata} !== {1'b1, old_v}) begin errors++; $display("FAIL collide_old: got v=%b d=%h want v=1 d=%h", s_rvalid, s_rdata, old_v); end
        checks++; if (cfg_regs !== model_flat()) begin errors++; $display("FAIL collide_cfg: got %h want %h", cfg_regs, model_flat()); end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0; s_bready = 1'b0;
        axi_read(32'h4, rd, resp, ok);
        checks++; if ({ok, rd, resp} !== {1'b1, 32'h7, 2'b00}) begin errors++; $display("FAIL collide_new: got ok=%b d=%h r=%b want ok=1 d=7 r=00", ok, rd, resp); end
        axi_read(32'hFFF0_0404, rd, resp, ok);
        checks++; if ({ok, rd, resp} !== {1'b1, 32'h7, 2'b00}) begin errors++; $display("FAIL alias_read: got ok=%b d=%h r=%b want ok=1 d=7 r=00", ok, rd, resp); end
    endtask

    task automatic test_random();
        logic [31:0] addr, data, rd, exp_d; logic [3:0] strb; logic [7:0] idx;
        logic [1:0] resp, exp_r; logic [NUM_CFG-1:0] pulse, exp_p; bit ok;
        for (int j = 0; j < NUM_STAT; j++) set_stat(j, $urandom());
        for (int n = 0; n < 80; n++) begin
            idx  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, NUM_CFG + NUM_STAT + 1));
            addr = $urandom();
            addr[9:2] = idx;
            if ($urandom_range(0, 1) == 0) begin
                data = $urandom();
                strb = 4'($urandom_range(0, 15));
                exp_p = '0;
                if (int'(idx) < NUM_CFG) begin
                    model_cfg[idx] = merge(model_cfg[idx], data, strb);
                    exp_p[idx] = 1'b1;
                    exp_r = 2'b00;
                end else begin
                    exp_r = 2'b10;
                end
                axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, pulse, ok);
                checks++; if ({ok, resp, pulse} !== {1'b1, exp_r, exp_p}) begin errors++; $display("FAIL rand_wr%0d idx=%0d: got ok=%b resp=%b pulse=%b want ok=1 resp=%b pulse=%b", n, idx, ok, resp, pulse, exp_r, exp_p); end
                checks++; if (cfg_regs !== model_flat()) begin errors++; $display("FAIL rand_cfg%0d: got %h want %h", n, cfg_regs, model_flat()); end
            end else begin
                if (int'(idx) < NUM_CFG) begin
                    exp_d = model_cfg[idx]; exp_r = 2'b00;
                end else if (int'(idx) < NUM_CFG + NUM_STAT) begin
                    exp_d = model_stat[int'(idx) - NUM_CFG]; exp_r = 2'b00;
                end else begin
                    exp_d = 32'h0; exp_r = 2'b10;
                end
                axi_read(addr, rd, resp, ok);
                checks++; if ({ok, rd, resp} !== {1'b1, exp_d, exp_r}) begin errors++; $display("FAIL rand_rd%0d idx=%0d: got ok=%b d=%h r=%b want ok=1 d=%h r=%b", n, idx, ok, rd, resp, exp_d, exp_r); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        s_wdata = 32'h1357_9BDF; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 32'h8; s_arvalid = 1'b1; s_rready = 1'b0; s_bready = 1'b0;
        @(negedge clk);
        s_wvalid = 1'b0; s_arvalid = 1'b0;
        checks++; if ({s_rvalid, s_wready} !== 2'b10) begin errors++; $display("FAIL mid_pre: got %b want 10", {s_rvalid, s_wready}); end
        #2 rstn = 1'b0;
        #1;
        model_reset();
        checks++; if ({s_bvalid, s_rvalid, s_rdata, s_rresp, s_bresp} !== 38'h0) begin errors++; $display("FAIL mid_rst_bus: got bv=%b rv=%b d=%h rr=%b br=%b want all 0", s_bvalid, s_rvalid, s_rdata, s_rresp, s_bresp); end
        checks++; if ({cfg_regs, cfg_wr_pulse} !== {model_flat(), 8'h00}) begin errors++; $display("FAIL mid_rst_cfg: got %h/%b want %h/0", cfg_regs, cfg_wr_pulse, model_flat()); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        s_awaddr = 32'h8; s_wdata = 32'hA5A5_1234; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        model_cfg[2] = 32'hA5A5_1234;
        checks++; if (cfg_regs !== model_flat()) begin errors++; $display("FAIL mid_after_cfg: got %h want %h", cfg_regs, model_flat()); end
        checks++; if ({cfg_wr_pulse, s_bvalid, s_bresp} !== {8'b0000_0100, 1'b1, 2'b00}) begin errors++; $display("FAIL mid_after_b: got pulse=%b bv=%b br=%b want 00000100 1 00", cfg_wr_pulse, s_bvalid, s_bresp); end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_w_first();
        test_errors();
        test_stat_read();
        test_collide();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_cfg_axil_regfile.md
Name: rr_cfg_axil_regfile

Overview:
AXI-Lite slave register file that terminates the rr_cfg_bus master port (M01, high 1MB of BAR1) of the BAR1 interconnect.
- Holds the record/replay configuration registers (enable, buffer base/size, mode) as flat outputs to the RR core.
- Provides read-only status words sampled from RR logic.
- Sits directly downstream of the BAR1 interconnect.

Parameters:
NUM_CFG, 8, number of 32-bit read/write config registers (word index 0..NUM_CFG-1).
NUM_STAT, 4, number of 32-bit read-only status words (word index NUM_CFG..NUM_CFG+NUM_STAT-1); NUM_CFG+NUM_STAT <= 256.
CFG_RESET_VAL, {NUM_CFG*32{1'b0}}, per-register reset values; reg i = bits [32*i+:32].

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_awaddr  in  32  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  32  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read valid
s_rready  in  1  read ready
cfg_regs  out  NUM_CFG*32  current config register contents
cfg_wr_pulse  out  NUM_CFG  one-cycle strobe per register on any accepted write to it
stat_in  in  NUM_STAT*32  status words, synchronous to clk

Behaviour:
- Reset: asynchronous, while rstn=0 forces the following; all handshakes abort and no partial write commits.
  - cfg_regs=CFG_RESET_VAL, cfg_wr_pulse=0.
  - s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0.
  - aw_held=0, w_held=0.
  - s_awready=1, s_wready=1, s_arready=1 after reset deasserts.
- Decode: word index = addr[9:2]; addr[31:10] and addr[1:0] are ignored.
- Write path: AW and W are accepted independently into holding registers aw_held and w_held.
  - s_awready = !aw_held && !s_bvalid; s_wready = !w_held && !s_bvalid.
  - Commit occurs in the cycle where both address and data are available, either held or arriving with valid&&ready.
  - The register update, cfg_wr_pulse and s_bvalid=1 all become visible on the next cycle. With both channels arriving together, latency is 1 cycle.
  - On commit, byte k of the register is updated only if wstrb[k]=1. wstrb=0 is still OKAY and still pulses cfg_wr_pulse.
  - Index < NUM_CFG: bresp=OKAY (2'b00).
  - Status or unmapped index: no state change, no pulse, bresp=SLVERR (2'b10).
  - s_bvalid holds with stable bresp until s_bready; the held flags clear on commit.
  - Next AW/W is accepted in the cycle after the B handshake. Throughput is 1 write per 2 cycles.
- Read path:
  - s_arready = !s_rvalid. On AR handshake, s_rvalid=1 next cycle.
  - s_rdata is the selected cfg register, or stat_in sampled in the AR handshake cycle.
  - Config and status indices: rresp=OKAY. Unmapped index: rdata=0, rresp=SLVERR.
  - rdata/rresp hold stable until s_rready; AR is re-accepted the cycle after the R handshake.
- Simultaneous events:
  - Read and write paths are fully independent.
  - A read of register i in the same cycle as a write commit to i returns the pre-write value.
  - cfg_wr_pulse is never asserted for two consecutive cycles for the same write.

Test Plan:
- Reset then AW+W together (addr 0x8, data 0xA5A5_1234, strb 4'hF) -> next cycle cfg_regs[95:64]=0xA5A51234, cfg_wr_pulse=8'b0000_0100 for 1 cycle, bvalid=1, bresp=00.
- W first (data 0xFFFF_FFFF, strb 4'b0101), AW 3 cycles later (addr 0x0) with bready=0 for 2 cycles -> reg0=0x00FF00FF; bvalid held 2 cycles; awready/wready stay low until cycle after B handshake.
- Write to status index 8 (addr 0x20) and unmapped 0x3FC -> bresp=10 both, cfg_regs unchanged, no pulse; read 0x3FC -> rdata=0, rresp=10.
- stat_in word0=0x1111 at AR cycle, changes to 0x2222 next cycle, rready=0 for 3 cycles -> rdata=0x1111 stable, arready=0 until handshake.
- Read addr 0x4 in same cycle as write commit to 0x4 (old 0x0, new 0x7) -> rdata=0x0, subsequent read returns 0x7; address bits 0xFFF0_0404 alias to reg1.
- Assert rstn=0 while w_held=1 and rvalid=1 -> all outputs to reset values immediately, no commit; first transaction after release behaves as in scenario 1.
